// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Raises cache_stall_o for misses and stores, and talks to a multi-cycle memory over req/ready.
module dcache_stall_ctrl #(
    parameter int unsigned SETS    = 64,
    parameter int unsigned INDEX_W = $clog2(SETS),
    parameter int unsigned TAG_W   = 32 - INDEX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    output logic [31:0] rdata_o,
    output logic        cache_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];
    logic [31:0]      resp_buf;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               is_store;
    logic [31:0]        line_data;
    logic [31:0]        merged;
    logic               unused_addr_bits;

    assign index            = addr_i[INDEX_W+1:2];
    assign tag              = addr_i[31:INDEX_W+2];
    assign line_data        = data_mem[index];
    assign hit              = valid[index] && (tag_mem[index] == tag);
    // A simultaneous read+write is handled as a store.
    assign is_store         = mem_write_i;
    assign unused_addr_bits = ^addr_i[1:0];

    assign merged[7:0]   = be_i[0] ? wdata_i[7:0]   : line_data[7:0];
    assign merged[15:8]  = be_i[1] ? wdata_i[15:8]  : line_data[15:8];
    assign merged[23:16] = be_i[2] ? wdata_i[23:16] : line_data[23:16];
    assign merged[31:24] = be_i[3] ? wdata_i[31:24] : line_data[31:24];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            resp_buf <= '0;
        end else begin
            state <= state_next;
            if (state == RD_MISS && mem_ready_i) begin
                valid[index] <= 1'b1;
                resp_buf     <= mem_rdata_i;
            end else if (state == WR_THRU && mem_ready_i) begin
                resp_buf <= '0;
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RD_MISS && mem_ready_i) begin
                tag_mem[index]  <= tag;
                data_mem[index] <= mem_rdata_i;
            end else if (state == IDLE && is_store && hit) begin
                data_mem[index] <= merged;
            end
        end
    end

    always_comb begin
        state_next    = state;
        cache_stall_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = {addr_i[31:2], 2'b00};
        mem_wdata_o   = '0;
        mem_be_o      = '0;
        rdata_o       = '0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    cache_stall_o = 1'b1;
                    state_next    = WR_THRU;
                end else if (mem_read_i) begin
                    if (hit) begin
                        rdata_o = line_data;
                    end else begin
                        cache_stall_o = 1'b1;
                        state_next    = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                cache_stall_o = 1'b1;
                mem_req_o     = 1'b1;
                if (mem_ready_i) state_next = RESP;
            end
            WR_THRU: begin
                cache_stall_o = 1'b1;
                mem_req_o     = 1'b1;
                mem_we_o      = 1'b1;
                mem_wdata_o   = wdata_i;
                mem_be_o      = be_i;
                if (mem_ready_i) state_next = RESP;
            end
            RESP: begin
                rdata_o    = resp_buf;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed bench for dcache_stall_ctrl: a scripted memory responds after a chosen latency
// and each step checks stall length, memory request fields and returned load data.
module tb_dcache_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] rdata_o;
    logic        cache_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int total = 0;
    int bad   = 0;

    int          st_stalls;
    logic [31:0] st_resp;
    logic        st_req;
    logic        st_we;
    logic [3:0]  st_be;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_done;
    logic        st_resp_req;

    always #5 clk = ~clk;

    dcache_stall_ctrl #(.SETS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .rdata_o      (rdata_o),
        .cache_stall_o(cache_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline access; memory answers on the lat-th cycle of mem_req_o.
    task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       input int lat, input logic [31:0] mrd);
        int reqc = 0;
        st_stalls = 0; st_req = 0; st_we = 0; st_be = '0; st_addr = '0;
        st_wdata = '0; st_done = 0;
        @(negedge clk);
        addr_i = a; wdata_i = wd; be_i = b; mem_read_i = rd; mem_write_i = wr;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!cache_stall_o) begin
                st_done = 1;
                break;
            end
            st_stalls++;
            if (mem_req_o) begin
                st_req = 1; st_we = mem_we_o; st_be = mem_be_o;
                st_addr = mem_addr_o; st_wdata = mem_wdata_o;
                reqc++;
                if (reqc == lat) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = mrd;
                end
            end
            @(negedge clk);
            mem_ready_i = 1'b0;
            mem_rdata_i = '0;
            #1;
        end
        st_resp     = rdata_o;
        st_resp_req = mem_req_o;
        @(negedge clk);
        mem_read_i = 0; mem_write_i = 0; be_i = '0; wdata_i = '0;
        #1;
    endtask

    initial begin
        rst = 1; addr_i = '0; wdata_i = '0; be_i = '0; mem_read_i = 0; mem_write_i = 0;
        mem_rdata_i = '0; mem_ready_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0; #1;
        chk("rst_stall", cache_stall_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_rdata", rdata_o, 0);

        // Cold load miss, memory latency 3 -> 4 stalled cycles.
        run(1, 0, 32'h100, 0, 0, 3, 32'hDEADBEEF);
        chk("ld1_done", st_done, 1);
        chk("ld1_stalls", st_stalls, 4);
        chk("ld1_we", st_we, 0);
        chk("ld1_addr", st_addr, 32'h100);
        chk("ld1_resp", st_resp, 32'hDEADBEEF);
        chk("ld1_resp_req", st_resp_req, 0);

        run(1, 0, 32'h100, 0, 0, 1, 32'h0);
        chk("hit1_stalls", st_stalls, 0);
        chk("hit1_req", st_req, 0);
        chk("hit1_data", st_resp, 32'hDEADBEEF);

        // Store hit, low halfword.
        run(0, 1, 32'h100, 32'h0000CAFE, 4'b0011, 2, 32'h0);
        chk("st1_stalls", st_stalls, 3);
        chk("st1_we", st_we, 1);
        chk("st1_be", st_be, 4'b0011);
        chk("st1_addr", st_addr, 32'h100);
        chk("st1_wdata", st_wdata, 32'h0000CAFE);
        chk("st1_resp", st_resp, 0);

        run(1, 0, 32'h100, 0, 0, 1, 32'h0);
        chk("hit2_stalls", st_stalls, 0);
        chk("hit2_data", st_resp, 32'hDEADCAFE);

        // Store miss to same index, different tag: must not allocate or disturb 0x100.
        run(0, 1, 32'h200, 32'h55555555, 4'hF, 1, 32'h0);
        chk("st2_stalls", st_stalls, 2);
        chk("st2_we", st_we, 1);
        chk("st2_addr", st_addr, 32'h200);
        run(1, 0, 32'h100, 0, 0, 1, 32'h0);
        chk("hit3_stalls", st_stalls, 0);
        chk("hit3_data", st_resp, 32'hDEADCAFE);

        run(1, 0, 32'h200, 0, 0, 2, 32'h12345678);
        chk("ld2_stalls", st_stalls, 3);
        chk("ld2_we", st_we, 0);
        chk("ld2_addr", st_addr, 32'h200);
        chk("ld2_resp", st_resp, 32'h12345678);

        run(1, 0, 32'h100, 0, 0, 1, 32'hDEADCAFE);
        chk("evict_stalls", st_stalls, 2);
        chk("evict_addr", st_addr, 32'h100);
        chk("evict_resp", st_resp, 32'hDEADCAFE);
        run(1, 0, 32'h200, 0, 0, 1, 32'h12345678);
        chk("evict2_stalls", st_stalls, 2);

        // Reset while RD_MISS, then a late ready.
        @(negedge clk); addr_i = 32'h100; mem_read_i = 1; #1;
        chk("mid_detect_stall", cache_stall_o, 1);
        @(negedge clk); #1;
        chk("mid_rdmiss_req", mem_req_o, 1);
        @(negedge clk); rst = 1; mem_read_i = 0; #1;
        @(negedge clk); rst = 0; mem_ready_i = 1; mem_rdata_i = 32'h00000BAD; #1;
        chk("mid_rst_stall", cache_stall_o, 0);
        chk("mid_rst_req", mem_req_o, 0);
        @(negedge clk); mem_ready_i = 0; mem_rdata_i = '0; #1;
        chk("mid_late_stall", cache_stall_o, 0);
        chk("mid_late_req", mem_req_o, 0);
        run(1, 0, 32'h100, 0, 0, 1, 32'h11112222);
        chk("mid_ld_stalls", st_stalls, 2);
        chk("mid_ld_resp", st_resp, 32'h11112222);

        run(1, 0, 32'h104, 0, 0, 1, 32'h0A0B0C0D);
        chk("ld104_stalls", st_stalls, 2);

        // Stray ready in IDLE, then back-to-back hits.
        @(negedge clk); mem_ready_i = 1; mem_rdata_i = 32'hFFFFFFFF; #1;
        chk("idle_rdy_stall", cache_stall_o, 0);
        @(negedge clk); mem_ready_i = 0; mem_rdata_i = '0; #1;
        chk("idle_rdy_stall2", cache_stall_o, 0);
        chk("idle_rdy_req", mem_req_o, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_read_i = 1;
            addr_i = (i % 2 == 0) ? 32'h100 : 32'h104;
            #1;
            chk("b2b_stall", cache_stall_o, 0);
            chk("b2b_data", rdata_o, (i % 2 == 0) ? 32'h11112222 : 32'h0A0B0C0D);
        end
        @(negedge clk); mem_read_i = 0; #1;
        chk("b2b_idle_rdata", rdata_o, 0);

        // Read and write together behaves as a full-word store hit.
        run(1, 1, 32'h104, 32'hAABBCCDD, 4'hF, 1, 32'h0);
        chk("both_we", st_we, 1);
        chk("both_stalls", st_stalls, 2);
        chk("both_resp", st_resp, 0);
        run(1, 0, 32'h104, 0, 0, 1, 32'h0);
        chk("both_hit_stalls", st_stalls, 0);
        chk("both_hit_data", st_resp, 32'hAABBCCDD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_stall_ctrl.md
Name: dcache_stall_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache controller in the Memory stage.
- Its `cache_stall_o` output is the source of the hazard unit's `CacheStall` input, which freezes Fetch through Writeback.
- It services loads and stores from the pipeline, and uses a simple req/ready handshake with a multi-cycle backing memory.
- Cache lines are one 32-bit word.

Parameters:
- SETS, 64, number of lines; power of two, ≥2.
- INDEX_W, $clog2(SETS), index width.
- TAG_W, 32-INDEX_W-2, tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr_i  in  32  byte address from the M stage; bits [1:0] ignored for line selection.
- wdata_i  in  32  store data, already byte-lane aligned.
- be_i  in  4  store byte enables.
- mem_read_i  in  1  load request in M.
- mem_write_i  in  1  store request in M.
- rdata_o  out  32  load data to the W pipeline register.
- cache_stall_o  out  1  freeze request to the hazard unit.
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  word-aligned address; bits [1:0] = 0.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  write byte enables.
- mem_rdata_i  in  32  read data, valid when mem_ready_i = 1.
- mem_ready_i  in  1  one-cycle completion pulse.

Behaviour:
- Storage per line: valid bit, TAG_W tag, 32-bit data.
  - index = addr_i[INDEX_W+1:2]; tag = addr_i[31:INDEX_W+2].
  - hit = valid[index] && tag matches.
- Reset (synchronous):
  - All valid bits cleared; FSM goes to IDLE.
  - Refill/response buffer cleared.
  - Outputs in the cycle after reset: mem_req_o = 0, mem_we_o = 0, cache_stall_o = 0, rdata_o = 0.
  - Reset mid-transaction abandons it; a later mem_ready_i pulse is ignored in IDLE.
- FSM states: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE:
  - Load hit: rdata_o = line data combinationally, cache_stall_o = 0, zero extra latency.
  - Load miss: cache_stall_o = 1 in the same cycle (combinational); next state RD_MISS.
  - Store (hit or miss): cache_stall_o = 1 in the same cycle; next state WR_THRU.
  - Store hit: the line's enabled bytes are merged on this edge.
  - Store miss: no allocation.
  - mem_read_i and mem_write_i both high: treated as a store (illegal from the decoder; defined anyway).
  - No request: stall = 0, rdata_o = 0.
- RD_MISS:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {addr_i[31:2], 2'b00}; cache_stall_o = 1.
  - On mem_ready_i: line written (valid = 1, tag, mem_rdata_i), mem_rdata_i captured in the response buffer, next state RESP.
- WR_THRU:
  - mem_req_o = 1, mem_we_o = 1, mem_wdata_o = wdata_i, mem_be_o = be_i; cache_stall_o = 1.
  - On mem_ready_i: next state RESP.
- Request hold rule: mem_req_o and all mem_* outputs stay stable from assertion until the cycle mem_ready_i = 1.
  - addr_i, wdata_i and be_i are stable during this time because the pipeline is frozen.
- RESP:
  - Exactly one cycle; cache_stall_o = 0, mem_req_o = 0.
  - rdata_o = response buffer for loads, 0 for stores.
  - New requests are not examined; the pipeline advances at the end of this cycle.
  - Next state is IDLE.
- Latency:
  - Load hit: 0 stall cycles.
  - Miss or store: memory latency N cycles (req to ready inclusive) plus the IDLE detect cycle, giving N+1 stalled cycles, then RESP.
- Ready discipline:
  - mem_ready_i in IDLE or RESP is ignored.
  - mem_rdata_i is sampled only on the ready cycle.
- Refilling a conflicting index overwrites the line unconditionally; write-through means no dirty state and no writeback.

Test Plan:
- Reset, then load 0x100 with memory returning 0xDEADBEEF after 3 cycles → stall high for 4 cycles, RESP rdata_o = 0xDEADBEEF; an immediate reload of 0x100 hits with 0 stall.
- Store 0x100 with be_i = 4'b0011, wdata_i = 0x0000CAFE after the line is cached → mem write seen with be 0011; a following load of 0x100 hits and returns 0xDEADCAFE.
- Store to uncached 0x200, then load 0x200 → the store does not allocate; the load misses and issues mem read at 0x200.
- SETS = 64: load 0x100, then load 0x200 (same index, different tag) → second access misses and evicts; reload 0x100 misses again.
- Assert rst while in RD_MISS, then pulse mem_ready_i → cycle after reset shows state IDLE, stall 0, mem_req_o 0; the late ready causes no line write; load 0x100 misses.
- mem_ready_i pulsed during IDLE with no request, and back-to-back hits over 10 cycles → no state change, cache_stall_o stays 0.
